// File: rtl/alu_result_stage_if.sv
// Handshake/result bundle between the ALU units, alu_result_stage and writeback.
// The slave modport is the stage's view; master is the issue/writeback side.
interface alu_result_stage_if #(
    parameter int data_wl = 16
);
    logic               valid_in;
    logic               ready_out;
    logic [data_wl-1:0] res_in;
    logic               z_flag_in;
    logic               s_flag_in;
    logic               c_flag_in;
    logic               ovr_flag_in;
    logic               op_active_in;
    logic               flag_we_in;
    logic               flag_clr_in;
    logic               valid_out;
    logic               ready_in;
    logic [data_wl-1:0] res_out;
    logic               z_flag_out;
    logic               s_flag_out;
    logic               c_flag_out;
    logic               ovr_flag_out;
    logic               err_out;

    modport slave (
        input  valid_in, res_in, z_flag_in, s_flag_in, c_flag_in, ovr_flag_in,
        input  op_active_in, flag_we_in, flag_clr_in, ready_in,
        output ready_out, valid_out, res_out,
        output z_flag_out, s_flag_out, c_flag_out, ovr_flag_out, err_out
    );

    modport master (
        output valid_in, res_in, z_flag_in, s_flag_in, c_flag_in, ovr_flag_in,
        output op_active_in, flag_we_in, flag_clr_in, ready_in,
        input  ready_out, valid_out, res_out,
        input  z_flag_out, s_flag_out, c_flag_out, ovr_flag_out, err_out
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry result FIFO, status register and illegal-op pulse.
// Optional build macro ALU_STICKY_OVR_EN makes the OVR flag sticky until cleared.
module alu_result_stage #(
    parameter int data_wl = 16
) (
    input logic               clk_in,
    input logic               rst_in,
    alu_result_stage_if.slave bus
);
    logic [1:0]         r_count;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_valid;
    logic [data_wl-1:0] r_mem [2];
    logic               r_z;
    logic               r_s;
    logic               r_c;
    logic               r_ovr;
    logic               r_err;

    logic               w_ready;
    logic               w_acc;
    logic               w_push;
    logic               w_pop;
    logic               w_illegal;
    logic               w_flag_ld;
    logic [1:0]         w_count_nxt;

    // ready depends only on occupancy and reset, never on writeback's ready
    assign w_ready   = ~rst_in & (r_count != 2'd2);
    assign w_acc     = bus.valid_in & w_ready;
    assign w_push    = w_acc & bus.op_active_in;
    assign w_illegal = w_acc & ~bus.op_active_in;
    assign w_pop     = r_valid & bus.ready_in;
    assign w_flag_ld = w_push & bus.flag_we_in;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count  <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_valid  <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.res_in;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
        end
    end

    // clear wins over a concurrent load; pops never touch the flags
    always_ff @(posedge clk_in) begin
        if (rst_in || bus.flag_clr_in) begin
            r_z   <= 1'b0;
            r_s   <= 1'b0;
            r_c   <= 1'b0;
            r_ovr <= 1'b0;
        end else if (w_flag_ld) begin
            r_z <= bus.z_flag_in;
            r_s <= bus.s_flag_in;
            r_c <= bus.c_flag_in;
`ifdef ALU_STICKY_OVR_EN
            r_ovr <= r_ovr | bus.ovr_flag_in;
`else
            r_ovr <= bus.ovr_flag_in;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_illegal;
        end
    end

    assign bus.ready_out    = w_ready;
    assign bus.valid_out    = r_valid;
    assign bus.res_out      = r_mem[r_rd_ptr];
    assign bus.z_flag_out   = r_z;
    assign bus.s_flag_out   = r_s;
    assign bus.c_flag_out   = r_c;
    assign bus.ovr_flag_out = r_ovr;
    assign bus.err_out      = r_err;
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_alu_result_stage;
    localparam int WL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_result_stage_if #(.data_wl(WL)) bus ();
    alu_result_stage #(.data_wl(WL)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [WL-1:0] m_q[$];
    logic [3:0]    m_flags;     // {z,s,c,ovr}
    logic          m_err;
    logic          m_res_zero;  // res_out known to be 0 (reset, nothing pushed yet)

    typedef struct {
        logic          rst, valid, op, we, clr, rdy;
        logic [WL-1:0] res;
        logic [3:0]    flags;
        logic          e_valid, e_ready, e_err, chk_res;
        logic [WL-1:0] e_res;
        logic [3:0]    e_flags;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic v, input logic op, input logic we,
                         input logic clr, input logic rdy, input logic [WL-1:0] res,
                         input logic [3:0] fl);
        rst              = r;
        bus.valid_in     = v;
        bus.op_active_in = op;
        bus.flag_we_in   = we;
        bus.flag_clr_in  = clr;
        bus.ready_in     = rdy;
        bus.res_in       = res;
        {bus.z_flag_in, bus.s_flag_in, bus.c_flag_in, bus.ovr_flag_in} = fl;
    endtask

    // Next-state of the model from the rules: bounded queue, flag register, error pulse.
    task automatic model_step();
        logic acc;
        logic [3:0] fin;
        fin = {bus.z_flag_in, bus.s_flag_in, bus.c_flag_in, bus.ovr_flag_in};
        if (rst) begin
            m_q.delete();
            m_flags    = 4'b0000;
            m_err      = 1'b0;
            m_res_zero = 1'b1;
            return;
        end
        acc = bus.valid_in && (m_q.size() < 2);
        if (m_q.size() > 0 && bus.ready_in) void'(m_q.pop_front());
        if (acc && bus.op_active_in) begin
            m_q.push_back(bus.res_in);
            m_res_zero = 1'b0;
        end
        m_err = acc && !bus.op_active_in;
        if (bus.flag_clr_in) m_flags = 4'b0000;
        else if (acc && bus.op_active_in && bus.flag_we_in) begin
`ifdef ALU_STICKY_OVR_EN
            m_flags = {fin[3:1], fin[0] | m_flags[0]};
`else
            m_flags = fin;
`endif
        end
    endtask

    task automatic model_check(input string tag);
        logic [3:0] dflags;
        dflags = {bus.z_flag_out, bus.s_flag_out, bus.c_flag_out, bus.ovr_flag_out};
        check({tag, " valid_out"}, 32'(bus.valid_out), 32'(m_q.size() > 0));
        check({tag, " ready_out"}, 32'(bus.ready_out), 32'(!rst && m_q.size() < 2));
        check({tag, " err_out"},   32'(bus.err_out),   32'(m_err));
        check({tag, " flags"},     32'(dflags),        32'(m_flags));
        if (m_q.size() > 0)  check({tag, " res_out"}, 32'(bus.res_out), 32'(m_q[0]));
        else if (m_res_zero) check({tag, " res_out"}, 32'(bus.res_out), 32'h0);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    task automatic addv(input logic r, input logic v, input logic op, input logic we,
                        input logic clr, input logic rdy, input logic [WL-1:0] res,
                        input logic [3:0] fl, input logic ev, input logic erdy,
                        input logic eerr, input logic cres, input logic [WL-1:0] eres,
                        input logic [3:0] efl);
        vec_t t;
        t.rst = r; t.valid = v; t.op = op; t.we = we; t.clr = clr; t.rdy = rdy;
        t.res = res; t.flags = fl; t.e_valid = ev; t.e_ready = erdy; t.e_err = eerr;
        t.chk_res = cres; t.e_res = eres; t.e_flags = efl;
        vecs.push_back(t);
    endtask

    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, '0, 4'b0000);
        m_q.delete();
        m_flags = '0; m_err = 1'b0; m_res_zero = 1'b1;
        @(posedge clk); #1;

        //   rst v op we clr rdy res      flags  | ev rdy err chk res      flags
        addv(1, 0, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 0, 0, 1, 16'h0000, 4'b0000);
        addv(0, 0, 0, 0, 0, 1, 16'h0000, 4'b0000, 0, 1, 0, 1, 16'h0000, 4'b0000);
        addv(0, 1, 1, 1, 0, 1, 16'h0001, 4'b1000, 1, 1, 0, 1, 16'h0001, 4'b1000);
        addv(0, 1, 1, 1, 0, 1, 16'h0002, 4'b0100, 1, 1, 0, 1, 16'h0002, 4'b0100);
        addv(0, 1, 1, 1, 0, 1, 16'h0003, 4'b0010, 1, 1, 0, 1, 16'h0003, 4'b0010);
        addv(0, 1, 1, 1, 0, 1, 16'h0004, 4'b1100, 1, 1, 0, 1, 16'h0004, 4'b1100);
        addv(0, 0, 0, 0, 0, 1, 16'h0000, 4'b0000, 0, 1, 0, 0, 16'h0000, 4'b1100);
        // stall: two pushes fill the FIFO, the third request is refused
        addv(0, 1, 1, 0, 0, 0, 16'hAAAA, 4'b0000, 1, 1, 0, 1, 16'hAAAA, 4'b1100);
        addv(0, 1, 1, 0, 0, 0, 16'h5555, 4'b0000, 1, 0, 0, 1, 16'hAAAA, 4'b1100);
        addv(0, 1, 1, 0, 0, 0, 16'h7777, 4'b0000, 1, 0, 0, 1, 16'hAAAA, 4'b1100);
        addv(0, 0, 0, 0, 0, 1, 16'h0000, 4'b0000, 1, 1, 0, 1, 16'h5555, 4'b1100);
        addv(0, 0, 0, 0, 0, 1, 16'h0000, 4'b0000, 0, 1, 0, 0, 16'h0000, 4'b1100);
        // illegal op between two legal ops
        addv(0, 1, 1, 1, 0, 1, 16'h0010, 4'b0100, 1, 1, 0, 1, 16'h0010, 4'b0100);
        addv(0, 1, 0, 1, 0, 1, 16'h1234, 4'b1111, 0, 1, 1, 0, 16'h0000, 4'b0100);
        addv(0, 1, 1, 1, 0, 1, 16'h0020, 4'b0010, 1, 1, 0, 1, 16'h0020, 4'b0010);
        // flag write-enable off, then clear beats a concurrent load
        addv(0, 1, 1, 1, 0, 1, 16'h0030, 4'b0000, 1, 1, 0, 1, 16'h0030, 4'b0000);
        addv(0, 1, 1, 0, 0, 1, 16'h0031, 4'b1000, 1, 1, 0, 1, 16'h0031, 4'b0000);
        addv(0, 1, 1, 1, 1, 1, 16'h0032, 4'b0010, 1, 1, 0, 1, 16'h0032, 4'b0000);
        addv(0, 0, 0, 0, 0, 1, 16'h0000, 4'b0000, 0, 1, 0, 0, 16'h0000, 4'b0000);
        // reset while full
        addv(0, 1, 1, 1, 0, 0, 16'h0101, 4'b1110, 1, 1, 0, 1, 16'h0101, 4'b1110);
        addv(0, 1, 1, 0, 0, 0, 16'h0202, 4'b0000, 1, 0, 0, 1, 16'h0101, 4'b1110);
        addv(1, 0, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 0, 0, 1, 16'h0000, 4'b0000);
        addv(0, 0, 0, 0, 0, 1, 16'h0000, 4'b0000, 0, 1, 0, 1, 16'h0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            string tg;
            logic [3:0] dfl;
            tg = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].we, vecs[i].clr,
                  vecs[i].rdy, vecs[i].res, vecs[i].flags);
            cycle(tg);
            dfl = {bus.z_flag_out, bus.s_flag_out, bus.c_flag_out, bus.ovr_flag_out};
            check({tg, " tbl valid_out"}, 32'(bus.valid_out), 32'(vecs[i].e_valid));
            check({tg, " tbl ready_out"}, 32'(bus.ready_out), 32'(vecs[i].e_ready));
            check({tg, " tbl err_out"},   32'(bus.err_out),   32'(vecs[i].e_err));
            check({tg, " tbl flags"},     32'(dfl),           32'(vecs[i].e_flags));
            if (vecs[i].chk_res)
                check({tg, " tbl res_out"}, 32'(bus.res_out), 32'(vecs[i].e_res));
        end

        // OVR stickiness and clear
        drive(0, 1, 1, 1, 0, 1, 16'h0F00, 4'b0001); cycle("ovr_set");
        check("ovr after set", 32'(bus.ovr_flag_out), 32'h1);
        drive(0, 1, 1, 1, 0, 1, 16'h0F01, 4'b0000); cycle("ovr_keep");
`ifdef ALU_STICKY_OVR_EN
        check("ovr sticky", 32'(bus.ovr_flag_out), 32'h1);
`else
        check("ovr tracks", 32'(bus.ovr_flag_out), 32'h0);
`endif
        drive(0, 0, 0, 0, 1, 1, 16'h0000, 4'b0000); cycle("ovr_clr");
        check("ovr cleared", 32'(bus.ovr_flag_out), 32'h0);

        // consecutive illegal accepts give consecutive pulses
        drive(0, 1, 0, 0, 0, 1, 16'h1111, 4'b0000); cycle("ill0");
        check("err pulse 1", 32'(bus.err_out), 32'h1);
        drive(0, 1, 0, 0, 0, 1, 16'h2222, 4'b0000); cycle("ill1");
        check("err pulse 2", 32'(bus.err_out), 32'h1);
        drive(0, 0, 0, 0, 0, 1, 16'h0000, 4'b0000); cycle("ill2");
        check("err pulse end", 32'(bus.err_out), 32'h0);
        check("ill no entry", 32'(bus.valid_out), 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0),
                  WL'($urandom), 4'($urandom));
            cycle($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
